// File: rtl/dct_rle_ctrl.sv
// Frame controller for an EEG DCT + run-length pipeline: it gathers 8 samples, runs the DCT
// core for DCT_LAT cycles and then serialises the coefficient buffer for BUF_LEN cycles.
module dct_rle_ctrl #(
    parameter int DCT_LAT = 3,
    parameter int BUF_LEN = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              s_valid,
    input  logic signed [7:0] s_data,
    output logic              s_ready,
    output logic signed [7:0] sample0,
    output logic signed [7:0] sample1,
    output logic signed [7:0] sample2,
    output logic signed [7:0] sample3,
    output logic signed [7:0] sample4,
    output logic signed [7:0] sample5,
    output logic signed [7:0] sample6,
    output logic signed [7:0] sample7,
    output logic              dct_en,
    output logic              dct_cs,
    output logic              buf_en,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_cnt
);

    localparam logic [3:0] DCT_LAST = 4'(DCT_LAT - 1);
    localparam logic [3:0] BUF_LAST = 4'(BUF_LEN - 1);

    typedef enum logic [1:0] {IDLE, FILL, COMPUTE, DRAIN} state_t;

    state_t            state_reg, state_next;
    logic [2:0]        idx_reg, idx_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic              stop_pend_reg, stop_pend_next;
    logic              xfer;
    logic              dct_reg, buf_reg;
    logic [15:0]       frame_cnt_reg;
    logic signed [7:0] sample_reg [8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            cnt_reg       <= '0;
            stop_pend_reg <= 1'b0;
            dct_reg       <= 1'b0;
            buf_reg       <= 1'b0;
            frame_cnt_reg <= '0;
            for (int i = 0; i < 8; i++) begin
                sample_reg[i] <= '0;
            end
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            cnt_reg       <= cnt_next;
            stop_pend_reg <= stop_pend_next;
            // Strobes are registered from the next state so they line up with the state itself.
            dct_reg       <= (state_next == COMPUTE);
            buf_reg       <= (state_next == DRAIN);
            if (frame_done) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
            if (xfer) begin
                sample_reg[idx_reg] <= s_data;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        cnt_next       = cnt_reg;
        stop_pend_next = stop_pend_reg;
        xfer           = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next     = FILL;
                    idx_next       = '0;
                    cnt_next       = '0;
                    stop_pend_next = stop;
                end
            end
            FILL: begin
                // A stop before the first sample abandons the empty frame right away.
                if (stop && (idx_reg == 3'd0)) begin
                    state_next     = IDLE;
                    stop_pend_next = 1'b0;
                end else begin
                    if (stop) begin
                        stop_pend_next = 1'b1;
                    end
                    if (s_valid) begin
                        xfer     = 1'b1;
                        idx_next = idx_reg + 3'd1;
                        if (idx_reg == 3'd7) begin
                            state_next = COMPUTE;
                            cnt_next   = '0;
                        end
                    end
                end
            end
            COMPUTE: begin
                if (stop) begin
                    stop_pend_next = 1'b1;
                end
                if (cnt_reg == DCT_LAST) begin
                    state_next = DRAIN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            DRAIN: begin
                if (stop) begin
                    stop_pend_next = 1'b1;
                end
                if (cnt_reg == BUF_LAST) begin
                    cnt_next = '0;
                    if (stop_pend_reg || stop) begin
                        state_next     = IDLE;
                        stop_pend_next = 1'b0;
                    end else begin
                        state_next = FILL;
                    end
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign s_ready    = (state_reg == FILL);
    assign busy       = (state_reg != IDLE);
    assign frame_done = (state_reg == DRAIN) && (cnt_reg == BUF_LAST);
    assign dct_en     = dct_reg;
    assign dct_cs     = dct_reg;
    assign buf_en     = buf_reg;
    assign frame_cnt  = frame_cnt_reg;

    assign sample0 = sample_reg[0];
    assign sample1 = sample_reg[1];
    assign sample2 = sample_reg[2];
    assign sample3 = sample_reg[3];
    assign sample4 = sample_reg[4];
    assign sample5 = sample_reg[5];
    assign sample6 = sample_reg[6];
    assign sample7 = sample_reg[7];

endmodule

// File: tb/tb_dct_rle_ctrl.sv
// Self-checking bench for dct_rle_ctrl: random frames compared against a frame-level model
// (8 captured samples, then DCT_LAT enable cycles, then BUF_LEN drain cycles).
module tb_dct_rle_ctrl;

    localparam int DCT_LAT = 3;
    localparam int BUF_LEN = 8;
    localparam int FRAME_TAIL = DCT_LAT + BUF_LEN;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              s_valid = 1'b0;
    logic signed [7:0] s_data = '0;
    logic              s_ready;
    logic signed [7:0] sample0, sample1, sample2, sample3, sample4, sample5, sample6, sample7;
    logic              dct_en, dct_cs, buf_en, busy, frame_done;
    logic [15:0]       frame_cnt;
    logic [63:0]       samples;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_cnt = '0;

    always #5 clk = ~clk;

    assign samples = {sample7, sample6, sample5, sample4, sample3, sample2, sample1, sample0};

    dct_rle_ctrl #(.DCT_LAT(DCT_LAT), .BUF_LEN(BUF_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .sample0(sample0), .sample1(sample1), .sample2(sample2), .sample3(sample3),
        .sample4(sample4), .sample5(sample5), .sample6(sample6), .sample7(sample7),
        .dct_en(dct_en), .dct_cs(dct_cs), .buf_en(buf_en), .busy(busy),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    task automatic pulse_start(input bit with_stop);
        @(negedge clk);
        start = 1'b1;
        stop  = with_stop;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    // Pure stimulus: pushes 8 samples through the handshake, optionally pulsing stop at index stop_at.
    task automatic feed_samples(input logic [63:0] fr, input int gap_pct, input int stop_at,
                                output bit timeout, output bit early);
        int n   = 0;
        int cyc = 0;
        timeout = 1'b0;
        early   = 1'b0;
        while (n < 8 && !timeout) begin
            @(negedge clk);
            if (dct_en || dct_cs || buf_en) early = 1'b1;
            stop    = (n == stop_at);
            s_valid = ($urandom_range(99) >= gap_pct);
            s_data  = s_valid ? fr[8*n +: 8] : 8'($urandom);
            if (s_valid && s_ready) n++;
            cyc++;
            if (cyc > 200) timeout = 1'b1;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        stop    = 1'b0;
        s_data  = '0;
    endtask

    task automatic run_frame(input logic [63:0] fr, input int gap_pct, input int stop_at,
                             input bit stop_compute, input bit to_idle, input string tag);
        bit         to, early, exp_dct, exp_done;
        logic [5:0] got_ctl, exp_ctl;
        feed_samples(fr, gap_pct, stop_at, to, early);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL fill_timeout[%s]: got no 8 transfers, required 8 within 200 cycles", tag);
            return;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL early_compute[%s]: got dct_en/buf_en during FILL, required 0", tag);
        end
        for (int c = 0; c < FRAME_TAIL; c++) begin
            @(negedge clk);
            exp_dct  = (c < DCT_LAT);
            exp_done = (c == FRAME_TAIL - 1);
            got_ctl  = {dct_en, dct_cs, buf_en, frame_done, s_ready, busy};
            exp_ctl  = {exp_dct, exp_dct, !exp_dct, exp_done, 1'b0, 1'b1};
            checks++;
            if (got_ctl !== exp_ctl) begin
                errors++;
                $display("FAIL ctrl[%s c=%0d]: got %b required %b", tag, c, got_ctl, exp_ctl);
            end
            checks++;
            if (samples !== fr) begin
                errors++;
                $display("FAIL samples_held[%s c=%0d]: got %h required %h", tag, c, samples, fr);
            end
            stop    = stop_compute && (c == 1);
            s_valid = (c != FRAME_TAIL - 1) ? 1'($urandom_range(1)) : 1'b0;
            s_data  = 8'($urandom);
        end
        @(negedge clk);
        model_cnt = model_cnt + 16'd1;
        checks++;
        if (frame_cnt !== model_cnt) begin
            errors++;
            $display("FAIL frame_cnt[%s]: got %h required %h", tag, frame_cnt, model_cnt);
        end
        got_ctl = {s_ready, busy, dct_en, buf_en, frame_done, 1'b0};
        exp_ctl = {!to_idle, !to_idle, 4'b0000};
        checks++;
        if (got_ctl !== exp_ctl) begin
            errors++;
            $display("FAIL after_frame[%s]: got %b required %b", tag, got_ctl, exp_ctl);
        end
        $display("frame %s: samples=%h frame_cnt=%h", tag, samples, frame_cnt);
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({s_ready, dct_en, dct_cs, buf_en, busy, frame_done} !== 6'b0 || frame_cnt !== 16'h0
            || samples !== 64'h0) begin
            errors++;
            $display("FAIL reset_state: got ctl=%b cnt=%h samples=%h required all 0",
                     {s_ready, dct_en, dct_cs, buf_en, busy, frame_done}, frame_cnt, samples);
        end
        start = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_holds_idle: got busy=%b required 0", busy);
        end
        start = 1'b0;
        rst_n = 1'b1;
        stop = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, s_ready, samples} !== {2'b00, 64'h0}) begin
                errors++;
                $display("FAIL idle_ignores[%0d]: got busy=%b s_ready=%b samples=%h required 0 0 0",
                         i, busy, s_ready, samples);
            end
        end
        stop = 1'b0;
        s_valid = 1'b0;
        $display("reset: idle after release, frame_cnt=%h", frame_cnt);
    endtask

    task automatic test_reset_drain;
        bit to, early;
        logic [63:0] fr;
        fr = {$urandom, $urandom};
        pulse_start(1'b0);
        feed_samples(fr, 0, -1, to, early);
        for (int c = 0; c <= DCT_LAT + 3; c++) @(negedge clk);
        checks++;
        if (buf_en !== 1'b1 || samples !== fr) begin
            errors++;
            $display("FAIL drain4_pre: got buf_en=%b samples=%h required 1 %h", buf_en, samples, fr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_ready, dct_en, dct_cs, buf_en, busy, frame_done} !== 6'b0 || frame_cnt !== 16'h0
            || samples !== 64'h0) begin
            errors++;
            $display("FAIL reset_async: got ctl=%b cnt=%h samples=%h required all 0",
                     {s_ready, dct_en, dct_cs, buf_en, busy, frame_done}, frame_cnt, samples);
        end
        model_cnt = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, frame_done, buf_en} !== 3'b000 || frame_cnt !== model_cnt) begin
                errors++;
                $display("FAIL reset_discard[%0d]: got busy=%b done=%b buf_en=%b cnt=%h required 0 0 0 %h",
                         i, busy, frame_done, buf_en, frame_cnt, model_cnt);
            end
        end
        $display("reset_drain: frame discarded, frame_cnt=%h", frame_cnt);
    endtask

    task automatic test_single_frame;
        pulse_start(1'b0);
        run_frame(64'h0807060504030201, 0, -1, 1'b0, 1'b0, "seq_1_to_8");
    endtask

    task automatic test_stop_fill_idle;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_idx0: got s_ready=%b required 1", s_ready);
        end
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, s_ready} !== 2'b00 || frame_cnt !== model_cnt) begin
            errors++;
            $display("FAIL stop_fill_idle: got busy=%b s_ready=%b cnt=%h required 0 0 %h",
                     busy, s_ready, frame_cnt, model_cnt);
        end
        $display("stop_fill_idle: busy=%b frame_cnt=%h", busy, frame_cnt);
    endtask

    task automatic test_valid_toggle;
        pulse_start(1'b0);
        run_frame({$urandom, $urandom}, 50, 3, 1'b0, 1'b1, "toggle_stop_mid_fill");
    endtask

    task automatic test_stop_compute;
        pulse_start(1'b0);
        run_frame({$urandom, $urandom}, 20, -1, 1'b1, 1'b1, "stop_in_compute");
    endtask

    task automatic test_start_stop;
        pulse_start(1'b1);
        run_frame({$urandom, $urandom}, 0, -1, 1'b0, 1'b1, "start_and_stop");
    endtask

    // s_valid held high: three frames, expected period 8 + DCT_LAT + BUF_LEN.
    task automatic test_back_to_back;
        logic [7:0]  q[$];
        int          done_at[$];
        logic [63:0] exp_s;
        int          cyc = 0;
        pulse_start(1'b0);
        s_valid = 1'b1;
        while (cyc < 100 && !(done_at.size() == 3 && !busy)) begin
            @(negedge clk);
            if (frame_done) begin
                done_at.push_back(cyc);
                for (int i = 0; i < 8; i++) exp_s[8*i +: 8] = q[q.size() - 8 + i];
                checks++;
                if (samples !== exp_s) begin
                    errors++;
                    $display("FAIL b2b_samples[%0d]: got %h required %h", done_at.size(), samples, exp_s);
                end
                $display("b2b frame %0d: samples=%h at cycle %0d", done_at.size(), samples, cyc);
            end
            stop = (done_at.size() == 2) && (cyc == done_at[1] + 3);
            s_data = 8'($urandom);
            if (s_ready && s_valid) q.push_back(s_data);
            cyc++;
        end
        s_valid = 1'b0;
        stop = 1'b0;
        model_cnt = model_cnt + 16'd3;
        checks++;
        if (done_at.size() != 3) begin
            errors++;
            $display("FAIL b2b_frames: got %0d frame_done pulses required 3", done_at.size());
        end else begin
            checks++;
            if (done_at[1] - done_at[0] != 8 + FRAME_TAIL || done_at[2] - done_at[1] != 8 + FRAME_TAIL) begin
                errors++;
                $display("FAIL b2b_period: got %0d,%0d required %0d", done_at[1] - done_at[0],
                         done_at[2] - done_at[1], 8 + FRAME_TAIL);
            end
        end
        checks++;
        if (busy !== 1'b0 || frame_cnt !== model_cnt) begin
            errors++;
            $display("FAIL b2b_end: got busy=%b cnt=%h required 0 %h", busy, frame_cnt, model_cnt);
        end
    endtask

    task automatic test_wrap;
        @(negedge clk);
        force dut.frame_cnt_reg = 16'hFFFF;
        #1;
        release dut.frame_cnt_reg;
        model_cnt = 16'hFFFF;
        @(negedge clk);
        checks++;
        if (frame_cnt !== model_cnt) begin
            errors++;
            $display("FAIL wrap_preload: got %h required %h", frame_cnt, model_cnt);
        end
        pulse_start(1'b0);
        run_frame({$urandom, $urandom}, 10, -1, 1'b1, 1'b1, "wrap");
    endtask

    initial begin
        test_reset();
        test_reset_drain();
        test_single_frame();
        test_stop_fill_idle();
        test_valid_toggle();
        test_stop_compute();
        test_start_stop();
        test_back_to_back();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dct_rle_ctrl.md
DCT_RLE_CTRL -- requirements
Module: dct_rle_ctrl

Interface
- REQ-001 SHALL have parameter DCT_LAT, default 3: cycles dct_en/dct_cs are held per frame (range 1..15).
- REQ-002 SHALL have parameter BUF_LEN, default 8: cycles buf_en is held per frame (range 1..15).
- REQ-003 clk  input  1  single clock; all state updates on its rising edge.
- REQ-004 rst_n  input  1  asynchronous, active-low reset.
- REQ-005 start  input  1  request to begin frame processing; honoured only in IDLE.
- REQ-006 stop  input  1  request to stop at the next frame boundary.
- REQ-007 s_valid  input  1  an EEG sample is present on s_data.
- REQ-008 s_data  input  8 signed  EEG sample.
- REQ-009 s_ready  output  1  controller accepts a sample this cycle.
- REQ-010 sample0..sample7  output  8 signed each  frame samples, driving the DCT inputs input0..input7.
- REQ-011 dct_en, dct_cs  output  1 each  DCT-core enable and chip select.
- REQ-012 buf_en  output  1  coefficient-buffer serialisation enable.
- REQ-013 busy  output  1  high in any state except IDLE.
- REQ-014 frame_done  output  1  single-cycle pulse on the last buf_en cycle of a frame.
- REQ-015 frame_cnt  output  16  count of completed frames.

Function
- REQ-016 FSM states: IDLE, FILL, COMPUTE, DRAIN; the state SHALL be registered.
- REQ-017 IDLE -> FILL when start=1; all other inputs are ignored in IDLE.
- REQ-018 FILL: s_ready=1 combinationally; a transfer occurs when s_valid & s_ready, writing s_data to sample[idx] and incrementing the 3-bit idx.
- REQ-019 On the transfer with idx=7, the FSM SHALL go FILL -> COMPUTE and idx SHALL wrap to 0.
- REQ-020 COMPUTE: dct_en=dct_cs=1 for exactly DCT_LAT cycles, then -> DRAIN; s_ready=0.
- REQ-021 DRAIN: buf_en=1 for exactly BUF_LEN cycles; s_ready=0.
- REQ-022 On the last DRAIN cycle, frame_done=1, and frame_cnt SHALL increment on the following edge, wrapping 0xFFFF -> 0x0000.
- REQ-023 After DRAIN the FSM SHALL go -> IDLE if stop_pend=1, else -> FILL.
- REQ-024 stop SHALL set the registered stop_pend in any non-IDLE state; stop_pend SHALL clear on entry to IDLE.
- REQ-025 stop asserted in FILL with idx=0 SHALL go -> IDLE immediately on that edge; with idx>0 the frame completes normally.
- REQ-026 start and stop high together in IDLE SHALL enter FILL with stop_pend=1, so exactly one frame is processed.
- REQ-027 sample0..7 SHALL be written only by FILL transfers and SHALL hold their values through COMPUTE and DRAIN.
- REQ-028 s_valid while s_ready=0 SHALL be ignored, with no sample captured.
- REQ-029 dct_en, dct_cs and buf_en SHALL be registered outputs, never asserted in the same cycle, and never high in IDLE or FILL.
- REQ-030 Frame period SHALL be 8 transfers + DCT_LAT + BUF_LEN cycles when s_valid is held high.

Reset
- REQ-031 rst_n=0 SHALL immediately force:
  - state=IDLE, idx=0, stop_pend=0;
  - sample0..7=0, frame_cnt=0;
  - s_ready=dct_en=dct_cs=buf_en=busy=frame_done=0.
- REQ-032 Reset asserted mid-frame SHALL discard the partial frame; after release the block waits in IDLE for start.

Verification
- REQ-033 Start pulse, s_valid held, s_data=1..8 ->
  - sample0..7=1..8;
  - dct_en high 3 cycles, then buf_en high 8 cycles;
  - frame_done on the 8th buf_en cycle; frame_cnt=1;
  - s_ready re-asserts the next cycle.
- REQ-034 s_valid toggled 1/0 during FILL -> exactly 8 transfers captured in order; COMPUTE entered only after the 8th.
- REQ-035 stop pulsed during COMPUTE -> frame finishes, frame_cnt=1, return to IDLE, busy=0, s_ready=0.
- REQ-036 start+stop in the same IDLE cycle -> one full frame, then IDLE.
- REQ-037 rst_n low during DRAIN cycle 4 -> all outputs 0 at once; no frame_done; frame_cnt stays 0.
- REQ-038 frame_cnt forced to 0xFFFF and one frame run -> frame_cnt=0x0000.
